// File: rtl/bus_controller.sv
`timescale 1ns/1ps
// bus_controller: 68000 bus-cycle controller with region decode,
// boot ROM overlay, wait states, watchdog bus error and IPL encoder.
module bus_controller #(
  parameter int         BOOT_CYCLES  = 4,
  parameter int         ROM_WAIT     = 2,
  parameter int         RAM_WAIT     = 0,
  parameter int         IO_WAIT      = 1,
  parameter int         BERR_TIMEOUT = 64,
  parameter logic [6:0] AVEC_MASK    = 7'h7E
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AS_N,
  input  logic       UDS_N,
  input  logic       LDS_N,
  input  logic       RW,
  input  logic [2:0] FC,
  input  logic [3:0] ADDR_H,
  input  logic [2:0] ADDR_L,
  input  logic [6:0] IRQ_N,
  input  logic       DTACK_EXT_N,
  output logic [1:0] CS_ROM_N,
  output logic [1:0] CS_RAM_N,
  output logic       CS_DUART_N,
  output logic       CS_EXP_N,
  output logic [6:0] IACK_N,
  output logic       DTACK_N,
  output logic       VPA_N,
  output logic       BERR_N,
  output logic [2:0] IPL_N,
  output logic       BOOT
);

  localparam int CW = $clog2(BERR_TIMEOUT + 1);
  localparam int BW = $clog2(BOOT_CYCLES + 2);
  localparam logic [CW-1:0] WD_LAST = CW'(BERR_TIMEOUT - 1);
  localparam logic [BW-1:0] BOOT_N = BW'(BOOT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ACK, S_AVEC, S_BERR
  } state_t;

  typedef enum logic [2:0] {
    K_NONE, K_ROM, K_RAM, K_IO,
    K_DUART, K_EXP, K_IACKV, K_IACKA
  } kind_t;

  state_t state, state_d;
  kind_t kind, kind_q, kind_d;
  logic armed, armed_d;
  logic [CW-1:0] wcnt, wcnt_d;
  logic [CW-1:0] wdog, wdog_d;
  logic [CW-1:0] wait_ld;
  logic [BW-1:0] bcnt, bcnt_d;
  logic boot_q, boot_d;
  logic done;

  logic is_iack, is_boot, is_map;
  logic avec, live;
  logic [7:0] avec_bits;
  logic [6:0] iack_oh;
  logic [1:0] bsel;
  logic [2:0] lvl;
  logic unused_rw;

  assign unused_rw = RW;

  assign is_iack = (FC == 3'b111);
  assign is_boot = ~is_iack & ~boot_q;
  assign is_map = ~is_iack & boot_q;
  assign avec_bits = {AVEC_MASK, 1'b0};
  assign avec = avec_bits[ADDR_L];

  always_comb begin
    kind = K_NONE;
    unique case (1'b1)
      is_iack: kind = avec ? K_IACKA : K_IACKV;
      is_boot: kind = K_ROM;
      is_map: begin
        unique case (ADDR_H)
          4'h0: kind = K_RAM;
          4'h8: kind = K_ROM;
          4'hC: kind = K_DUART;
          4'hD: kind = K_EXP;
          4'hF: kind = K_IO;
          default: kind = K_NONE;
        endcase
      end
      default: kind = K_NONE;
    endcase
  end

  always_comb begin
    wait_ld = '0;
    unique case (kind)
      K_ROM: wait_ld = CW'(ROM_WAIT);
      K_RAM: wait_ld = CW'(RAM_WAIT);
      K_IO: wait_ld = CW'(IO_WAIT);
      default: wait_ld = '0;
    endcase
  end

  always_comb begin
    iack_oh = '0;
    for (int i = 0; i < 7; i++)
      iack_oh[i] = (ADDR_L == 3'(i + 1));
  end

  // A cycle only drives selects once AS_N has been seen high since reset
  assign live = ~AS_N & (armed | (state != S_IDLE));
  assign bsel = {~UDS_N, ~LDS_N};

  assign CS_ROM_N = ~(bsel & {2{live & (kind == K_ROM)}});
  assign CS_RAM_N = ~(bsel & {2{live & (kind == K_RAM)}});
  assign CS_DUART_N = ~(live & (kind == K_DUART) & ~LDS_N);
  assign CS_EXP_N = ~(live & (kind == K_EXP));
  assign IACK_N = ~(iack_oh & {7{live & (kind == K_IACKV)}});
  assign BOOT = boot_q;

  always_comb begin
    lvl = 3'd0;
    for (int i = 0; i < 7; i++)
      if (!IRQ_N[i]) lvl = 3'(i + 1);
  end

  always_comb begin
    state_d = state;
    armed_d = armed | AS_N;
    wcnt_d = wcnt;
    wdog_d = wdog;
    kind_d = kind_q;
    done = 1'b0;
    case (state)
      S_IDLE: begin
        if (armed && !AS_N) begin
          state_d = S_WAIT;
          armed_d = 1'b0;
          wcnt_d = wait_ld;
          wdog_d = '0;
          kind_d = kind;
        end
      end
      S_WAIT: begin
        if (wcnt != '0) wcnt_d = wcnt - 1'b1;
        wdog_d = wdog + 1'b1;
        if (AS_N) begin
          state_d = S_IDLE;
        end else if (wdog == WD_LAST) begin
          state_d = S_BERR;
        end else if (wcnt == '0) begin
          unique case (kind_q)
            K_ROM, K_RAM, K_IO: state_d = S_ACK;
            K_DUART, K_EXP, K_IACKV:
              if (!DTACK_EXT_N) state_d = S_ACK;
            K_IACKA: state_d = S_AVEC;
            default: state_d = S_WAIT;
          endcase
        end
      end
      S_ACK, S_AVEC, S_BERR: begin
        if (AS_N) begin
          state_d = S_IDLE;
          done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bcnt_d = bcnt;
    if (done && bcnt != BOOT_N) bcnt_d = bcnt + 1'b1;
    boot_d = boot_q | (done && bcnt_d == BOOT_N);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      armed <= 1'b0;
      wcnt <= '0;
      wdog <= '0;
      kind_q <= K_NONE;
      bcnt <= '0;
      boot_q <= 1'b0;
      DTACK_N <= 1'b1;
      VPA_N <= 1'b1;
      BERR_N <= 1'b1;
      IPL_N <= 3'b111;
    end else begin
      state <= state_d;
      armed <= armed_d;
      wcnt <= wcnt_d;
      wdog <= wdog_d;
      kind_q <= kind_d;
      bcnt <= bcnt_d;
      boot_q <= boot_d;
      DTACK_N <= ~(state_d == S_ACK);
      VPA_N <= ~(state_d == S_AVEC);
      BERR_N <= ~(state_d == S_BERR);
      IPL_N <= ~lvl;
    end
  end

endmodule

// File: tb/tb_bus_controller.sv
`timescale 1ns/1ps
// tb_bus_controller: directed vector table plus hand-written
// sequences for boot overlay, wait/ext DTACK, BERR, reset and abort.
module tb_bus_controller;

  logic       CLK = 1'b0;
  logic       RST;
  logic       AS_N;
  logic       UDS_N;
  logic       LDS_N;
  logic       RW;
  logic [2:0] FC;
  logic [3:0] ADDR_H;
  logic [2:0] ADDR_L;
  logic [6:0] IRQ_N;
  logic       DTACK_EXT_N;
  logic [1:0] CS_ROM_N;
  logic [1:0] CS_RAM_N;
  logic       CS_DUART_N;
  logic       CS_EXP_N;
  logic [6:0] IACK_N;
  logic       DTACK_N;
  logic       VPA_N;
  logic       BERR_N;
  logic [2:0] IPL_N;
  logic       BOOT;

  bus_controller dut (
    .CLK(CLK), .RST(RST), .AS_N(AS_N),
    .UDS_N(UDS_N), .LDS_N(LDS_N), .RW(RW),
    .FC(FC), .ADDR_H(ADDR_H), .ADDR_L(ADDR_L),
    .IRQ_N(IRQ_N), .DTACK_EXT_N(DTACK_EXT_N),
    .CS_ROM_N(CS_ROM_N), .CS_RAM_N(CS_RAM_N),
    .CS_DUART_N(CS_DUART_N), .CS_EXP_N(CS_EXP_N),
    .IACK_N(IACK_N), .DTACK_N(DTACK_N),
    .VPA_N(VPA_N), .BERR_N(BERR_N),
    .IPL_N(IPL_N), .BOOT(BOOT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] fc;
    logic [3:0] ah;
    logic [2:0] al;
    logic       u;
    logic       l;
    logic       rw;
    logic       ext;
    logic [1:0] rom;
    logic [1:0] ram;
    logic       duart;
    logic       xp;
    logic [6:0] iack;
    logic [2:0] term;
    logic [7:0] lat;
  } vec_t;

  localparam logic [2:0] T_DTACK = 3'b110;
  localparam logic [2:0] T_VPA = 3'b101;
  localparam logic [2:0] T_BERR = 3'b011;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl [13];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] term();
    return {BERR_N, VPA_N, DTACK_N};
  endfunction

  task automatic drive(input vec_t v);
    FC = v.fc;
    ADDR_H = v.ah;
    ADDR_L = v.al;
    UDS_N = v.u;
    LDS_N = v.l;
    RW = v.rw;
    DTACK_EXT_N = v.ext;
    AS_N = 1'b0;
  endtask

  task automatic release_bus();
    AS_N = 1'b1;
    UDS_N = 1'b1;
    LDS_N = 1'b1;
    DTACK_EXT_N = 1'b1;
  endtask

  task automatic bus_cycle(input string nm, input vec_t v,
                           input int hold);
    int k;
    logic ok;
    drive(v);
    #1;
    check($sformatf("%s rom", nm), CS_ROM_N, v.rom);
    check($sformatf("%s ram", nm), CS_RAM_N, v.ram);
    check($sformatf("%s duart", nm), CS_DUART_N, v.duart);
    check($sformatf("%s exp", nm), CS_EXP_N, v.xp);
    check($sformatf("%s iack", nm), IACK_N, v.iack);
    step();
    k = 0;
    while (term() == 3'b111 && k < 200) begin
      step();
      k++;
    end
    check($sformatf("%s latency", nm), k, v.lat);
    check($sformatf("%s term", nm), term(), v.term);
    if (hold > 0) begin
      ok = 1'b1;
      repeat (hold) begin
        step();
        if (term() !== v.term) ok = 1'b0;
      end
      check($sformatf("%s hold", nm), ok, 1);
    end
    release_bus();
    step();
    check($sformatf("%s release", nm), term(), 3'b111);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic ok;

    tbl[0]  = '{3'd5, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1,
                2'b11, 2'b00, 1'b1, 1'b1, 7'h7F, T_DTACK, 8'd1};
    tbl[1]  = '{3'd5, 4'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1,
                2'b11, 2'b01, 1'b1, 1'b1, 7'h7F, T_DTACK, 8'd1};
    tbl[2]  = '{3'd6, 4'h8, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1,
                2'b10, 2'b11, 1'b1, 1'b1, 7'h7F, T_DTACK, 8'd3};
    tbl[3]  = '{3'd5, 4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1,
                2'b11, 2'b11, 1'b1, 1'b1, 7'h7F, T_DTACK, 8'd2};
    tbl[4]  = '{3'd5, 4'hD, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0,
                2'b11, 2'b11, 1'b1, 1'b0, 7'h7F, T_DTACK, 8'd1};
    tbl[5]  = '{3'd5, 4'hC, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0,
                2'b11, 2'b11, 1'b0, 1'b1, 7'h7F, T_DTACK, 8'd1};
    tbl[6]  = '{3'd5, 4'hC, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                2'b11, 2'b11, 1'b1, 1'b1, 7'h7F, T_DTACK, 8'd1};
    tbl[7]  = '{3'd7, 4'h0, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1,
                2'b11, 2'b11, 1'b1, 1'b1, 7'h7F, T_VPA, 8'd1};
    tbl[8]  = '{3'd7, 4'h0, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0,
                2'b11, 2'b11, 1'b1, 1'b1, 7'b1111110, T_DTACK, 8'd1};
    tbl[9]  = '{3'd7, 4'hF, 3'd7, 1'b1, 1'b0, 1'b1, 1'b1,
                2'b11, 2'b11, 1'b1, 1'b1, 7'h7F, T_VPA, 8'd1};
    tbl[10] = '{3'd7, 4'h0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0,
                2'b11, 2'b11, 1'b1, 1'b1, 7'h7F, T_DTACK, 8'd1};
    tbl[11] = '{3'd6, 4'h8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1,
                2'b00, 2'b11, 1'b1, 1'b1, 7'h7F, T_DTACK, 8'd3};
    tbl[12] = '{3'd7, 4'h0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1,
                2'b11, 2'b11, 1'b1, 1'b1, 7'h7F, T_VPA, 8'd1};

    RST = 1'b1;
    AS_N = 1'b1;
    UDS_N = 1'b1;
    LDS_N = 1'b1;
    RW = 1'b1;
    FC = 3'd5;
    ADDR_H = 4'h0;
    ADDR_L = 3'd0;
    IRQ_N = 7'h7F;
    DTACK_EXT_N = 1'b1;
    step();
    step();
    RST = 1'b0;
    check("reset term", term(), 3'b111);
    check("reset ipl", IPL_N, 3'b111);
    check("reset boot", BOOT, 0);
    check("reset rom", CS_ROM_N, 2'b11);
    check("reset iack", IACK_N, 7'h7F);
    step();

    v = '{3'd5, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1,
          2'b00, 2'b11, 1'b1, 1'b1, 7'h7F, T_DTACK, 8'd3};
    for (int i = 0; i < 4; i++) begin
      bus_cycle($sformatf("boot%0d", i), v, 0);
      check($sformatf("boot%0d flag", i), BOOT, (i == 3) ? 1 : 0);
    end
    bus_cycle("post boot ram", tbl[0], 0);

    for (int i = 0; i < 13; i++)
      bus_cycle($sformatf("vec%0d", i), tbl[i], 0);

    v = '{3'd5, 4'hC, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1,
          2'b11, 2'b11, 1'b0, 1'b1, 7'h7F, T_DTACK, 8'd0};
    drive(v);
    step();
    ok = 1'b1;
    repeat (10) begin
      step();
      if (DTACK_N !== 1'b1) ok = 1'b0;
    end
    check("duart wait no dtack", ok, 1);
    check("duart cs", CS_DUART_N, 0);
    DTACK_EXT_N = 1'b0;
    step();
    check("duart ext dtack", DTACK_N, 0);
    release_bus();
    step();
    check("duart release", DTACK_N, 1);

    v = '{3'd5, 4'h3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1,
          2'b11, 2'b11, 1'b1, 1'b1, 7'h7F, T_BERR, 8'd64};
    bus_cycle("unmapped berr", v, 5);

    IRQ_N = 7'b1111010;
    #1;
    check("ipl before edge", IPL_N, 3'b111);
    step();
    check("ipl lvl3", IPL_N, 3'b100);
    IRQ_N = 7'b0111110;
    step();
    check("ipl lvl7", IPL_N, 3'b000);
    IRQ_N = 7'h7F;
    step();
    check("ipl none", IPL_N, 3'b111);

    v = '{3'd6, 4'h8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1,
          2'b00, 2'b11, 1'b1, 1'b1, 7'h7F, T_DTACK, 8'd3};
    drive(v);
    step();
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("midwait rst term", term(), 3'b111);
    check("midwait rst cs",
          {CS_ROM_N, CS_RAM_N, CS_DUART_N, CS_EXP_N}, 6'h3F);
    check("midwait rst iack", IACK_N, 7'h7F);
    check("midwait rst boot", BOOT, 0);
    ok = 1'b1;
    repeat (5) begin
      step();
      if (DTACK_N !== 1'b1 || CS_ROM_N !== 2'b11) ok = 1'b0;
    end
    check("no cycle until AS_N high", ok, 1);
    release_bus();
    step();
    v = '{3'd5, 4'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1,
          2'b00, 2'b11, 1'b1, 1'b1, 7'h7F, T_DTACK, 8'd3};
    bus_cycle("after rst", v, 0);

    drive(v);
    step();
    step();
    release_bus();
    ok = 1'b1;
    repeat (4) begin
      step();
      if (DTACK_N !== 1'b1) ok = 1'b0;
    end
    check("abort no dtack", ok, 1);
    for (int i = 0; i < 3; i++) begin
      bus_cycle($sformatf("abort%0d", i), v, 0);
      check($sformatf("abort%0d boot", i), BOOT, (i == 2) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
